udma_periph_cfg_regs_mc: RTL and testbench
==========================================

// Module: udma_periph_cfg_regs_mc
// PURPOSE
// Multi-channel uDMA peripheral configuration register file. It is the parametrised successor of the
// two-channel UART config interface. It has NUM_CH generic DMA channels, each with its own
// 8-word register window, plus a common window. The common window holds a sticky event/error
// status register (clear-on-read), an IRQ enable mask and the peripheral setup register.
// It sits between the uDMA cfg bus and the channel controllers/peripheral core, and drives irq_o.
// PARAMETERS
// L2_AWIDTH_NOAL  12  channel start/current address width
// TRANS_SIZE      16  channel transfer size width
// NUM_CH          2   number of DMA channels (1..8)
// STATUS_W        3   peripheral error status bits
// ADDR_W          3+$clog2(NUM_CH+1)  cfg word address width (derived, not overridable)
// PORTS
// clk_i              in   1                      clock
// rstn_i             in   1                      synchronous active-low reset
// cfg_data_i         in   32                     write data
// cfg_addr_i         in   ADDR_W                 word address; [ADDR_W-1:3]=window, [2:0]=offset
// cfg_valid_i        in   1                      access strobe
// cfg_rwn_i          in   1                      1=read, 0=write
// cfg_data_o         out  32                     read data, combinational
// cfg_ready_o        out  1                      tied 1
// cfg_startaddr_o    out  NUM_CH*L2_AWIDTH_NOAL  per-channel start address, ch k at slice k
// cfg_size_o         out  NUM_CH*TRANS_SIZE      per-channel size
// cfg_continuous_o   out  NUM_CH                 per-channel continuous mode
// cfg_en_o           out  NUM_CH                 per-channel enable pulse
// cfg_clr_o          out  NUM_CH                 per-channel clear pulse
// cfg_en_i           in   NUM_CH                 channel busy
// cfg_pending_i      in   NUM_CH                 channel has queued transfer
// cfg_curr_addr_i    in   NUM_CH*L2_AWIDTH_NOAL  current address
// cfg_bytes_left_i   in   NUM_CH*TRANS_SIZE      bytes remaining
// ch_done_i          in   NUM_CH                 1-cycle end-of-transfer event
// status_i           in   STATUS_W               1-cycle error events from peripheral
// setup_o            out  32                     setup register contents (divider/bits/parity/en)
// irq_o              out  1                      |(sticky & irq_en), registered
// BEHAVIOUR
// - Write = cfg_valid_i & ~cfg_rwn_i; Read = cfg_valid_i & cfg_rwn_i.
// - Window w<NUM_CH = channel w. Offsets: 0 SADDR, 1 SIZE, 2 CFG. Other offsets unmapped.
// - Window NUM_CH = common. Offsets: 0 STATUS, 1 SETUP, 2 IRQ_EN. Other windows/offsets unmapped.
// - Unmapped access: reads return 0; writes have no effect.
// - SADDR/SIZE writes: take data LSBs, effective next cycle. Read returns cfg_curr_addr_i / cfg_bytes_left_i, zero-extended.
// - CFG write: bit0 -> continuous (held); bit4 -> en, bit5 -> clr.
//   en/clr are registered 1-cycle pulses: high exactly in the cycle after the write, then 0.
// - CFG read = {26'h0, pending, en_i, 3'h0, continuous}.
// - STATUS layout: [STATUS_W-1:0] error, [STATUS_W+NUM_CH-1:STATUS_W] done; sticky bits.
//   - Any status_i/ch_done_i high sets the matching bit next cycle.
//   - A read returns the current value and clears the register next cycle.
//   - Event in the same cycle as the read: the bit stays set (set beats clear).
// - IRQ_EN: STATUS_W+NUM_CH bit mask, read/write. irq_o = registered |(sticky & irq_en), 1-cycle latency.
// - SETUP: full 32-bit read/write, driven on setup_o.
// - Reset (rstn_i low at posedge): all registers, pulses, sticky, mask and irq_o = 0.
//   Reset beats a simultaneous write or event.
// TESTING
// - Reset, then read every mapped address -> 0 (channel regs reflect inputs); irq_o=0, en/clr=0.
// - Write ch1 CFG 0x31 -> cycle+1: cfg_en_o[1]=cfg_clr_o[1]=1, continuous[1]=1. Cycle+2: pulses 0.
// - Write ch0 SADDR 0xABC, SIZE 0x1234 -> outputs slice 0 = 0xABC/0x1234; ch1 slices unchanged.
// - status_i=3'b010 pulse with IRQ_EN=0x2 -> STATUS reads 0x2, irq_o=1. Read clears: next read 0, irq_o=0.
// - ch_done_i[0] coincident with STATUS read -> read returns old value; bit 3 set afterwards.
// - Write unmapped window 3 / offset 5 -> no register changes; reads return 0. Reset mid-pulse -> pulse drops.

Source files
------------

// File: rtl/udma_periph_cfg_regs_mc.sv
// Multi-channel uDMA peripheral config register file: per-channel windows plus a common
// window holding sticky event status, IRQ mask and the peripheral setup register.
module udma_periph_cfg_regs_mc #(
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned TRANS_SIZE     = 16,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned STATUS_W       = 3
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic [31:0]                         cfg_data_i,
    input  logic [3+$clog2(NUM_CH+1)-1:0]       cfg_addr_i,
    input  logic                                cfg_valid_i,
    input  logic                                cfg_rwn_i,
    output logic [31:0]                         cfg_data_o,
    output logic                                cfg_ready_o,
    output logic [NUM_CH*L2_AWIDTH_NOAL-1:0]    cfg_startaddr_o,
    output logic [NUM_CH*TRANS_SIZE-1:0]        cfg_size_o,
    output logic [NUM_CH-1:0]                   cfg_continuous_o,
    output logic [NUM_CH-1:0]                   cfg_en_o,
    output logic [NUM_CH-1:0]                   cfg_clr_o,
    input  logic [NUM_CH-1:0]                   cfg_en_i,
    input  logic [NUM_CH-1:0]                   cfg_pending_i,
    input  logic [NUM_CH*L2_AWIDTH_NOAL-1:0]    cfg_curr_addr_i,
    input  logic [NUM_CH*TRANS_SIZE-1:0]        cfg_bytes_left_i,
    input  logic [NUM_CH-1:0]                   ch_done_i,
    input  logic [STATUS_W-1:0]                 status_i,
    output logic [31:0]                         setup_o,
    output logic                                irq_o
);

    localparam int unsigned ADDR_W = 3 + $clog2(NUM_CH + 1);
    localparam int unsigned WIN_W  = ADDR_W - 3;
    localparam int unsigned EVT_W  = STATUS_W + NUM_CH;

    localparam logic [2:0] OFF_SADDR  = 3'd0;
    localparam logic [2:0] OFF_SIZE   = 3'd1;
    localparam logic [2:0] OFF_CFG    = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_SETUP  = 3'd1;
    localparam logic [2:0] OFF_IRQEN  = 3'd2;

    logic [WIN_W-1:0]          win;
    logic [2:0]                off;
    logic                      wr;
    logic                      rd;
    logic                      common_sel;
    logic                      status_rd;
    logic [NUM_CH-1:0]         ch_sel;

    logic [L2_AWIDTH_NOAL-1:0] saddr_q [NUM_CH];
    logic [TRANS_SIZE-1:0]     size_q  [NUM_CH];
    logic [NUM_CH-1:0]         cont_q;
    logic [NUM_CH-1:0]         en_q;
    logic [NUM_CH-1:0]         clr_q;
    logic [EVT_W-1:0]          sticky_q;
    logic [EVT_W-1:0]          sticky_d;
    logic [EVT_W-1:0]          irq_en_q;
    logic [31:0]               setup_q;
    logic                      irq_q;

    assign win        = cfg_addr_i[ADDR_W-1:3];
    assign off        = cfg_addr_i[2:0];
    assign wr         = cfg_valid_i & ~cfg_rwn_i;
    assign rd         = cfg_valid_i & cfg_rwn_i;
    assign common_sel = (win == WIN_W'(NUM_CH));
    assign status_rd  = rd & common_sel & (off == OFF_STATUS);

    always_comb begin
        ch_sel = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            ch_sel[k] = (win == WIN_W'(k));
        end
    end

    // Read-clear applies first so an event in the same cycle survives.
    assign sticky_d = (status_rd ? '0 : sticky_q) | {ch_done_i, status_i};

    // Register state; en/clr are single-cycle pulses.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                saddr_q[k] <= '0;
                size_q[k]  <= '0;
            end
            cont_q   <= '0;
            en_q     <= '0;
            clr_q    <= '0;
            sticky_q <= '0;
            irq_en_q <= '0;
            setup_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            en_q  <= '0;
            clr_q <= '0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (wr && ch_sel[k]) begin
                    case (off)
                        OFF_SADDR: saddr_q[k] <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
                        OFF_SIZE:  size_q[k]  <= cfg_data_i[TRANS_SIZE-1:0];
                        OFF_CFG: begin
                            cont_q[k] <= cfg_data_i[0];
                            en_q[k]   <= cfg_data_i[4];
                            clr_q[k]  <= cfg_data_i[5];
                        end
                        default: ;
                    endcase
                end
            end
            if (wr && common_sel) begin
                case (off)
                    OFF_SETUP: setup_q  <= cfg_data_i;
                    OFF_IRQEN: irq_en_q <= cfg_data_i[EVT_W-1:0];
                    default: ;
                endcase
            end
            sticky_q <= sticky_d;
            irq_q    <= |(sticky_q & irq_en_q);
        end
    end

    // Combinational read mux; channel address/size reads reflect live channel state.
    always_comb begin
        cfg_data_o = '0;
        if (rd) begin
            if (common_sel) begin
                case (off)
                    OFF_STATUS: cfg_data_o = 32'(sticky_q);
                    OFF_SETUP:  cfg_data_o = setup_q;
                    OFF_IRQEN:  cfg_data_o = 32'(irq_en_q);
                    default:    cfg_data_o = '0;
                endcase
            end else begin
                for (int k = 0; k < int'(NUM_CH); k++) begin
                    if (ch_sel[k]) begin
                        case (off)
                            OFF_SADDR: cfg_data_o = 32'(cfg_curr_addr_i[k*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]);
                            OFF_SIZE:  cfg_data_o = 32'(cfg_bytes_left_i[k*TRANS_SIZE +: TRANS_SIZE]);
                            OFF_CFG:   cfg_data_o = {26'h0, cfg_pending_i[k], cfg_en_i[k], 3'h0, cont_q[k]};
                            default:   cfg_data_o = '0;
                        endcase
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch_out
        assign cfg_startaddr_o[g*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL] = saddr_q[g];
        assign cfg_size_o[g*TRANS_SIZE +: TRANS_SIZE]              = size_q[g];
    end

    assign cfg_continuous_o = cont_q;
    assign cfg_en_o         = en_q;
    assign cfg_clr_o        = clr_q;
    assign cfg_ready_o      = 1'b1;
    assign setup_o          = setup_q;
    assign irq_o            = irq_q;

endmodule

// File: tb/tb_udma_periph_cfg_regs_mc.sv
// Self-checking bench for udma_periph_cfg_regs_mc: vector table of register accesses plus
// hand sequences for pulses, sticky status, IRQ latency and reset priority.
module tb_udma_periph_cfg_regs_mc;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned L2     = 12;
    localparam int unsigned TS     = 16;
    localparam int unsigned SW     = 3;
    localparam int unsigned AW     = 5;

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic [31:0]          cfg_data_i;
    logic [AW-1:0]        cfg_addr_i;
    logic                 cfg_valid_i;
    logic                 cfg_rwn_i;
    logic [31:0]          cfg_data_o;
    logic                 cfg_ready_o;
    logic [NUM_CH*L2-1:0] cfg_startaddr_o;
    logic [NUM_CH*TS-1:0] cfg_size_o;
    logic [NUM_CH-1:0]    cfg_continuous_o;
    logic [NUM_CH-1:0]    cfg_en_o;
    logic [NUM_CH-1:0]    cfg_clr_o;
    logic [NUM_CH-1:0]    cfg_en_i;
    logic [NUM_CH-1:0]    cfg_pending_i;
    logic [NUM_CH*L2-1:0] cfg_curr_addr_i;
    logic [NUM_CH*TS-1:0] cfg_bytes_left_i;
    logic [NUM_CH-1:0]    ch_done_i;
    logic [SW-1:0]        status_i;
    logic [31:0]          setup_o;
    logic                 irq_o;

    udma_periph_cfg_regs_mc #(
        .L2_AWIDTH_NOAL(L2), .TRANS_SIZE(TS), .NUM_CH(NUM_CH), .STATUS_W(SW)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i),
        .cfg_valid_i(cfg_valid_i), .cfg_rwn_i(cfg_rwn_i),
        .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
        .cfg_startaddr_o(cfg_startaddr_o), .cfg_size_o(cfg_size_o),
        .cfg_continuous_o(cfg_continuous_o), .cfg_en_o(cfg_en_o), .cfg_clr_o(cfg_clr_o),
        .cfg_en_i(cfg_en_i), .cfg_pending_i(cfg_pending_i),
        .cfg_curr_addr_i(cfg_curr_addr_i), .cfg_bytes_left_i(cfg_bytes_left_i),
        .ch_done_i(ch_done_i), .status_i(status_i),
        .setup_o(setup_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic        rwn;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One bus access; reads push the expectation and compare at the following negedge.
    task automatic access(input string name, input logic rwn, input logic [4:0] addr,
                          input logic [31:0] data, input logic [31:0] exp);
        sb_t e;
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = rwn;
        cfg_addr_i  = addr;
        cfg_data_i  = data;
        if (rwn) sb_q.push_back('{name, exp});
        @(negedge clk_i);
        if (rwn) begin
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL %s: scoreboard empty", name);
            end else begin
                e = sb_q.pop_front();
                chk(e.name, cfg_data_o, e.exp);
            end
        end
        @(posedge clk_i);
        #1;
        cfg_valid_i = 1'b0;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = '0;
        cfg_data_i  = '0;
    endtask

    function automatic vec_t mk(input string n, input logic r, input logic [4:0] a,
                                input logic [31:0] d, input logic [31:0] x);
        vec_t v;
        v.name = n; v.rwn = r; v.addr = a; v.data = d; v.exp = x;
        return v;
    endfunction

    initial begin
        // Addresses: ch0 0..2, ch1 8..10, common 16 STATUS / 17 SETUP / 18 IRQ_EN, window 3 = 24..31.
        vecs.push_back(mk("rst_ch0_saddr",  1'b1, 5'd0,  32'h0, 32'h0000_03C2));
        vecs.push_back(mk("rst_ch0_size",   1'b1, 5'd1,  32'h0, 32'h0000_0010));
        vecs.push_back(mk("rst_ch0_cfg",    1'b1, 5'd2,  32'h0, 32'h0000_0020));
        vecs.push_back(mk("rst_ch1_saddr",  1'b1, 5'd8,  32'h0, 32'h0000_05A1));
        vecs.push_back(mk("rst_ch1_size",   1'b1, 5'd9,  32'h0, 32'h0000_0F00));
        vecs.push_back(mk("rst_ch1_cfg",    1'b1, 5'd10, 32'h0, 32'h0000_0010));
        vecs.push_back(mk("rst_status",     1'b1, 5'd16, 32'h0, 32'h0));
        vecs.push_back(mk("rst_setup",      1'b1, 5'd17, 32'h0, 32'h0));
        vecs.push_back(mk("rst_irqen",      1'b1, 5'd18, 32'h0, 32'h0));
        vecs.push_back(mk("wr_setup",       1'b0, 5'd17, 32'hDEAD_BEEF, 32'h0));
        vecs.push_back(mk("rd_setup",       1'b1, 5'd17, 32'h0, 32'hDEAD_BEEF));
        vecs.push_back(mk("wr_irqen",       1'b0, 5'd18, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk("rd_irqen_mask",  1'b1, 5'd18, 32'h0, 32'h0000_001F));
        vecs.push_back(mk("wr_win3",        1'b0, 5'd24, 32'h1234_5678, 32'h0));
        vecs.push_back(mk("rd_win3",        1'b1, 5'd24, 32'h0, 32'h0));
        vecs.push_back(mk("rd_win3_off5",   1'b1, 5'd29, 32'h0, 32'h0));
        vecs.push_back(mk("wr_ch0_off5",    1'b0, 5'd5,  32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk("rd_ch0_off5",    1'b1, 5'd5,  32'h0, 32'h0));
        vecs.push_back(mk("wr_com_off5",    1'b0, 5'd21, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk("rd_com_off5",    1'b1, 5'd21, 32'h0, 32'h0));
        vecs.push_back(mk("rd_setup_kept",  1'b1, 5'd17, 32'h0, 32'hDEAD_BEEF));
        vecs.push_back(mk("rd_irqen_kept",  1'b1, 5'd18, 32'h0, 32'h0000_001F));
        vecs.push_back(mk("wr_irqen_zero",  1'b0, 5'd18, 32'h0, 32'h0));

        rstn_i = 1'b0; cfg_data_i = '0; cfg_addr_i = '0; cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1;
        cfg_en_i = 2'b10; cfg_pending_i = 2'b01;
        cfg_curr_addr_i  = {12'h5A1, 12'h3C2};
        cfg_bytes_left_i = {16'h0F00, 16'h0010};
        ch_done_i = '0; status_i = '0;
        tick(); tick();
        rstn_i = 1'b1;
        tick();

        chk("rst_irq",      32'(irq_o), 32'h0);
        chk("rst_en",       32'(cfg_en_o), 32'h0);
        chk("rst_clr",      32'(cfg_clr_o), 32'h0);
        chk("rst_cont",     32'(cfg_continuous_o), 32'h0);
        chk("rst_saddr_o",  32'(cfg_startaddr_o), 32'h0);
        chk("rst_size_o",   cfg_size_o, 32'h0);
        chk("rst_setup_o",  setup_o, 32'h0);
        chk("ready",        32'(cfg_ready_o), 32'h1);

        foreach (vecs[i]) access(vecs[i].name, vecs[i].rwn, vecs[i].addr, vecs[i].data, vecs[i].exp);
        chk("setup_o_val", setup_o, 32'hDEAD_BEEF);
        chk("win3_no_effect_saddr", 32'(cfg_startaddr_o), 32'h0);

        // Channel 1 CFG write: pulses for exactly one cycle, continuous held.
        access("wr_ch1_cfg", 1'b0, 5'd10, 32'h31, 32'h0);
        chk("ch1_en_pulse",  32'(cfg_en_o),  32'h2);
        chk("ch1_clr_pulse", 32'(cfg_clr_o), 32'h2);
        chk("ch1_cont",      32'(cfg_continuous_o), 32'h2);
        tick();
        chk("ch1_en_drop",   32'(cfg_en_o),  32'h0);
        chk("ch1_clr_drop",  32'(cfg_clr_o), 32'h0);
        chk("ch1_cont_held", 32'(cfg_continuous_o), 32'h2);
        access("rd_ch1_cfg", 1'b1, 5'd10, 32'h0, 32'h11);

        // Channel 0 address/size, channel 1 slices untouched.
        access("wr_ch0_saddr", 1'b0, 5'd0, 32'hFFFF_FABC, 32'h0);
        access("wr_ch0_size",  1'b0, 5'd1, 32'h0001_1234, 32'h0);
        chk("ch0_saddr_o", 32'(cfg_startaddr_o), 32'h0000_0ABC);
        chk("ch0_size_o",  cfg_size_o, 32'h0000_1234);

        // Error event with mask: irq lags sticky by one cycle; read clears.
        access("wr_irqen_2", 1'b0, 5'd18, 32'h2, 32'h0);
        status_i = 3'b010;
        tick();
        status_i = '0;
        chk("irq_latency", 32'(irq_o), 32'h0);
        tick();
        chk("irq_set", 32'(irq_o), 32'h1);
        access("rd_status_err", 1'b1, 5'd16, 32'h0, 32'h2);
        access("rd_status_clr", 1'b1, 5'd16, 32'h0, 32'h0);
        chk("irq_clr", 32'(irq_o), 32'h0);

        // Unmasked event raises no irq.
        status_i = 3'b001;
        tick();
        status_i = '0;
        tick();
        chk("irq_masked", 32'(irq_o), 32'h0);

        // Done event coincident with read: old value returned, done bit survives.
        ch_done_i = 2'b01;
        access("rd_status_coinc", 1'b1, 5'd16, 32'h0, 32'h1);
        ch_done_i = '0;
        access("rd_status_done",  1'b1, 5'd16, 32'h0, 32'h8);
        access("rd_status_empty", 1'b1, 5'd16, 32'h0, 32'h0);

        // Reset mid-pulse drops the pulse and state.
        access("wr_ch1_cfg2", 1'b0, 5'd10, 32'h31, 32'h0);
        chk("pulse_before_rst", 32'(cfg_en_o), 32'h2);
        rstn_i = 1'b0;
        tick();
        chk("rst_pulse_drop", 32'(cfg_en_o), 32'h0);
        chk("rst_cont_drop",  32'(cfg_continuous_o), 32'h0);
        chk("rst_setup_drop", setup_o, 32'h0);

        // Reset beats a simultaneous write and event.
        status_i = 3'b100;
        access("wr_setup_in_rst", 1'b0, 5'd17, 32'h5555_AAAA, 32'h0);
        status_i = '0;
        chk("rst_beats_write", setup_o, 32'h0);
        rstn_i = 1'b1;
        tick();
        access("rst_beats_event", 1'b1, 5'd16, 32'h0, 32'h0);
        chk("rst_saddr_final", 32'(cfg_startaddr_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
